// File: rtl/antirrebote_multi.sv
// Multi-channel button/switch debouncer: each input is synchronised and then qualified
// by its own four-state FSM and stability counter. The block emits a clean level plus rise/fall pulses.
module antirrebote_multi #(
    parameter int CHANNELS     = 4,
    parameter int CNT_BITS     = 22,
    parameter int STABLE_COUNT = 4194304,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] boton,
    output logic [CHANNELS-1:0] db,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    typedef enum logic [1:0] {
        ALAIRE     = 2'd0,
        WAIT_ONE   = 2'd1,
        PRESIONADO = 2'd2,
        WAIT_ZERO  = 2'd3
    } state_t;

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(STABLE_COUNT - 1);

    if (CHANNELS < 1 || SYNC_STAGES < 2 || STABLE_COUNT < 1 ||
        longint'(STABLE_COUNT) > (longint'(1) << CNT_BITS)) begin : g_bad_params
        $error("antirrebote_multi: illegal parameter combination");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_t                 state_q, state_nxt;
        logic [CNT_BITS-1:0]    cnt_q, cnt_nxt;
        logic                   cnt_done;
        logic                   db_q, rise_q, fall_q;
        logic                   db_nxt, rise_nxt, fall_nxt;

        assign s        = sync_q[SYNC_STAGES-1];
        assign cnt_done = (cnt_q == CNT_LAST);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], boton[i]};
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ALAIRE;
                cnt_q   <= '0;
                db_q    <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_nxt;
                cnt_q   <= cnt_nxt;
                db_q    <= db_nxt;
                rise_q  <= rise_nxt;
                fall_q  <= fall_nxt;
            end
        end

        // Counter only runs while a new level is being qualified; any bounce drops it back to 0.
        always_comb begin
            state_nxt = state_q;
            cnt_nxt   = '0;
            case (state_q)
                ALAIRE: begin
                    if (s) state_nxt = WAIT_ONE;
                end
                WAIT_ONE: begin
                    if (!s)            state_nxt = ALAIRE;
                    else if (cnt_done) state_nxt = PRESIONADO;
                    else               cnt_nxt   = cnt_q + 1'b1;
                end
                PRESIONADO: begin
                    if (!s) state_nxt = WAIT_ZERO;
                end
                WAIT_ZERO: begin
                    if (s)             state_nxt = PRESIONADO;
                    else if (cnt_done) state_nxt = ALAIRE;
                    else               cnt_nxt   = cnt_q + 1'b1;
                end
                default: state_nxt = ALAIRE;
            endcase
        end

        always_comb begin
            db_nxt   = db_q;
            rise_nxt = 1'b0;
            fall_nxt = 1'b0;
            case (state_q)
                WAIT_ONE: begin
                    if (s && cnt_done) begin
                        db_nxt   = 1'b1;
                        rise_nxt = 1'b1;
                    end
                end
                WAIT_ZERO: begin
                    if (!s && cnt_done) begin
                        db_nxt   = 1'b0;
                        fall_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        assign db[i]   = db_q;
        assign rise[i] = rise_q;
        assign fall[i] = fall_q;
    end

endmodule
